frequency_result_reader: RTL and testbench
==========================================

Name: frequency_result_reader

Overview:
- AXI4-Lite read-only master that collects frequency-analyzer results from the register bank.
- The analyzer manager fills that bank through the axi_slave_impl register port, then raises irq.
- On the rising edge of irq, this block reads REGISTERS_NUMBER consecutive 32-bit registers over AR/R, buffers them, and publishes them atomically with a done pulse.
- Sits between the manager's s00_axi slave port (via interconnect) and downstream decision logic.

Parameters:
C_M00_AXI_ADDR_WIDTH, 10, AXI address width
C_M00_AXI_DATA_WIDTH, 32, AXI data width; register stride = C_M00_AXI_DATA_WIDTH/8 bytes
BASE_ADDRESS, 0, byte address of first result register
REGISTERS_NUMBER, 6, registers read per run (pixel0 f0/f1, pixel1 f0/f1, pixel2 f0/f1)
TIMEOUT_CYCLES, 1024, max wait cycles for arready or rvalid before abort

Ports:
m00_axi_aclk  in  1  single clock
m00_axi_aresetn  in  1  reset, asynchronous, active-low
irq  in  1  results-ready from manager, synchronous to m00_axi_aclk; start on rising edge
m00_axi_araddr  out  C_M00_AXI_ADDR_WIDTH  read address
m00_axi_arprot  out  3  constant 3'b000
m00_axi_arvalid  out  1  address valid
m00_axi_arready  in  1  address ready
m00_axi_rdata  in  C_M00_AXI_DATA_WIDTH  read data
m00_axi_rresp  in  2  read response
m00_axi_rvalid  in  1  read data valid
m00_axi_rready  out  1  read data ready
results  out  REGISTERS_NUMBER*C_M00_AXI_DATA_WIDTH  word i at [i*DW +: DW]
busy  out  1  run in progress
done  out  1  one-cycle pulse at end of every run (success or abort)
error  out  1  last run aborted by bad RRESP
timeout  out  1  last run aborted by timeout
overrun  out  1  irq edge arrived while busy

Behaviour:
- Reset (async assert, sync-released use): state IDLE; all outputs 0, results 0, internal irq_d 0, pending 0, shadow buffer 0. Reset mid-run drops arvalid/rready immediately and discards the shadow buffer.
- Start: irq==1 && irq_d==0 sampled in IDLE at edge k. At edge k, error/timeout/overrun clear, index=0, busy=1. State is ADDR from k+1.
- States: IDLE -> ADDR -> DATA -> (ADDR | COMMIT) -> IDLE; any -> ABORT -> IDLE.
- ADDR:
  - arvalid=1, araddr=BASE_ADDRESS + index*stride.
  - araddr held stable until handshake; arvalid never deasserted before arready.
  - Handshake -> DATA.
- DATA:
  - rready=1.
  - rvalid && rresp[1]==0 -> shadow[index]=rdata.
  - If index==REGISTERS_NUMBER-1 -> COMMIT; else index+1 -> ADDR.
  - rvalid && rresp[1]==1 (SLVERR/DECERR) -> ABORT with error=1.
  - EXOKAY (2'b01) is treated as OKAY.
- Only one outstanding read; rready is 0 outside DATA.
- Timeout:
  - Wait counter resets on entering ADDR or DATA and increments each cycle without a handshake.
  - Reaching TIMEOUT_CYCLES -> ABORT with timeout=1.
  - arvalid drops on exit (accepted protocol deviation; slave must tolerate it).
- COMMIT (1 cycle): results<=shadow, done=1, busy drops -> IDLE.
- ABORT (1 cycle): results unchanged, done=1, busy drops -> IDLE. error/timeout hold until the next start.
- Zero-wait slave (arready=1, rvalid one cycle after AR handshake):
  - AR handshake for read i at k+1+2i.
  - Last R handshake at k+2*REGISTERS_NUMBER.
  - done and new results at k+2*REGISTERS_NUMBER+1 (k+13 for 6).
- irq edge while busy:
  - overrun=1 and pending=1 (max one pending).
  - After done, IDLE immediately starts a new run (next edge), which clears overrun.
- irq held high: no retrigger. irq toggling during COMMIT/ABORT counts as busy.
- Address arithmetic is modulo 2^C_M00_AXI_ADDR_WIDTH (wraps, no error).

Test Plan:
- Zero-wait slave with registers 5000,10000,15000,20000,25000,30000 at 0x00..0x14. irq 0->1 at edge 10 -> araddr sequence 0x00,0x04,…,0x14; done at edge 23; results words 0..5 equal those values; busy 1 during edges 10..22.
- Slave inserts 3-cycle arready and 2-cycle rvalid waits per read -> araddr/arvalid stable while waiting; rready only in DATA; results correct; done once.
- rresp=2'b10 on read 3 after a prior good run -> done pulse, error=1, results still hold the prior run's values, no further AR issued.
- arready held 0 with TIMEOUT_CYCLES=16 -> ABORT 16 cycles after entering ADDR, timeout=1, done pulse, arvalid 0 afterwards.
- Second irq edge during run -> overrun=1; second run starts the edge after the first done; overrun clears at its start; exactly two done pulses.
- aresetn asserted mid-DATA of read 2 -> arvalid/rready/busy 0 immediately, results 0. After release, next irq edge runs a full clean read starting at BASE_ADDRESS.

Source files
------------

// File: rtl/frequency_result_reader.sv
// AXI4-Lite read master: on an irq rising edge, fetch REGISTERS_NUMBER result
// words, buffer them, and publish them together with a one-cycle done pulse.
//
// Ports:
//   m00_axi_aclk, m00_axi_aresetn : clock, async active-low reset
//   irq                           : results-ready; a rising edge starts a run
//   m00_axi_ar*, m00_axi_r*       : AXI4-Lite read address / read data channels
//   results                       : word i at [i*DW +: DW], updated only on success
//   busy, done                    : run in progress, end-of-run pulse
//   error, timeout, overrun       : last run's abort cause, irq edge while busy
module frequency_result_reader #(
    parameter int C_M00_AXI_ADDR_WIDTH = 10,
    parameter int C_M00_AXI_DATA_WIDTH = 32,
    parameter int BASE_ADDRESS         = 0,
    parameter int REGISTERS_NUMBER     = 6,
    parameter int TIMEOUT_CYCLES       = 1024
) (
    input  logic                                             m00_axi_aclk,
    input  logic                                             m00_axi_aresetn,
    input  logic                                             irq,
    output logic [C_M00_AXI_ADDR_WIDTH-1:0]                  m00_axi_araddr,
    output logic [2:0]                                       m00_axi_arprot,
    output logic                                             m00_axi_arvalid,
    input  logic                                             m00_axi_arready,
    input  logic [C_M00_AXI_DATA_WIDTH-1:0]                  m00_axi_rdata,
    input  logic [1:0]                                       m00_axi_rresp,
    input  logic                                             m00_axi_rvalid,
    output logic                                             m00_axi_rready,
    output logic [REGISTERS_NUMBER*C_M00_AXI_DATA_WIDTH-1:0] results,
    output logic                                             busy,
    output logic                                             done,
    output logic                                             error,
    output logic                                             timeout,
    output logic                                             overrun
);

    localparam int AW     = C_M00_AXI_ADDR_WIDTH;
    localparam int DW     = C_M00_AXI_DATA_WIDTH;
    localparam int IDX_W  = (REGISTERS_NUMBER > 1) ? $clog2(REGISTERS_NUMBER) : 1;
    localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [AW-1:0]    BASE     = AW'(BASE_ADDRESS);
    localparam logic [AW-1:0]    STEP     = AW'(DW / 8);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REGISTERS_NUMBER - 1);
    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_COMMIT,
        S_ABORT
    } state_t;

    state_t state_q, state_d;

    logic             irq_d_q;
    logic             pending_q;
    logic             busy_q;
    logic             done_q;
    logic             error_q;
    logic             timeout_q;
    logic             overrun_q;
    logic [IDX_W-1:0] index_q;
    logic [CNT_W-1:0] wait_q;
    logic [DW-1:0]    shadow_q [REGISTERS_NUMBER];
    logic [REGISTERS_NUMBER*DW-1:0] shadow_flat;
    logic [REGISTERS_NUMBER*DW-1:0] results_q;

    logic irq_rise;
    logic start;
    logic rd_last;
    logic wait_exp;
    logic unused_rresp_lsb;

    // EXOKAY is accepted as OKAY, so only the upper response bit matters.
    assign unused_rresp_lsb = m00_axi_rresp[0];

    assign irq_rise = irq & ~irq_d_q;
    // A queued edge from a busy period starts the next run straight from IDLE.
    assign start    = (state_q == S_IDLE) & (irq_rise | pending_q);
    assign rd_last  = (index_q == LAST_IDX);
    assign wait_exp = (wait_q == WAIT_MAX);

    assign m00_axi_arprot = 3'b000;
    assign results        = results_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;
    assign timeout        = timeout_q;
    assign overrun        = overrun_q;

    always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
        if (!m00_axi_aresetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_ADDR;
            end
            S_ADDR: begin
                if (m00_axi_arready) state_d = S_DATA;
                else if (wait_exp)   state_d = S_ABORT;
            end
            S_DATA: begin
                if (m00_axi_rvalid) begin
                    if (m00_axi_rresp[1]) state_d = S_ABORT;
                    else if (rd_last)     state_d = S_COMMIT;
                    else                  state_d = S_ADDR;
                end else if (wait_exp) begin
                    state_d = S_ABORT;
                end
            end
            S_COMMIT: state_d = S_IDLE;
            S_ABORT:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Handshake outputs decode straight from state so an async reset drops
    // them at once; araddr is held by index_q, which only moves in DATA.
    always_comb begin
        m00_axi_arvalid = 1'b0;
        m00_axi_rready  = 1'b0;
        m00_axi_araddr  = '0;
        unique case (state_q)
            S_ADDR: begin
                m00_axi_arvalid = 1'b1;
                m00_axi_araddr  = BASE + AW'(index_q) * STEP;
            end
            S_DATA: begin
                m00_axi_rready = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        shadow_flat = '0;
        for (int i = 0; i < REGISTERS_NUMBER; i++) begin
            shadow_flat[i*DW +: DW] = shadow_q[i];
        end
    end

    always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
        if (!m00_axi_aresetn) begin
            irq_d_q   <= 1'b0;
            pending_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;
            index_q   <= '0;
            wait_q    <= '0;
            results_q <= '0;
            for (int i = 0; i < REGISTERS_NUMBER; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            irq_d_q <= irq;
            done_q  <= 1'b0;

            if (start) begin
                busy_q    <= 1'b1;
                index_q   <= '0;
                wait_q    <= '0;
                error_q   <= 1'b0;
                timeout_q <= 1'b0;
                overrun_q <= 1'b0;
                pending_q <= 1'b0;
            end else if (irq_rise && state_q != S_IDLE) begin
                overrun_q <= 1'b1;
                pending_q <= 1'b1;
            end

            unique case (state_q)
                S_ADDR: begin
                    if (m00_axi_arready) wait_q    <= '0;
                    else if (wait_exp)   timeout_q <= 1'b1;
                    else                 wait_q    <= wait_q + CNT_W'(1);
                end
                S_DATA: begin
                    if (m00_axi_rvalid) begin
                        wait_q <= '0;
                        if (m00_axi_rresp[1]) begin
                            error_q <= 1'b1;
                        end else begin
                            shadow_q[index_q] <= m00_axi_rdata;
                            if (!rd_last) index_q <= index_q + IDX_W'(1);
                        end
                    end else if (wait_exp) begin
                        timeout_q <= 1'b1;
                    end else begin
                        wait_q <= wait_q + CNT_W'(1);
                    end
                end
                S_COMMIT: begin
                    results_q <= shadow_flat;
                    done_q    <= 1'b1;
                    busy_q    <= 1'b0;
                end
                S_ABORT: begin
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frequency_result_reader.sv
// Directed bench for frequency_result_reader with a behavioural AXI4-Lite
// read slave (configurable AR/R wait states and an error-injection index).
`timescale 1ns/1ps
module tb_frequency_result_reader;

    localparam int AW   = 10;
    localparam int DW   = 32;
    localparam int NREG = 6;
    localparam int TMO  = 16;
    localparam int RW   = NREG * DW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          irq;
    logic [AW-1:0] araddr;
    logic [2:0]    arprot;
    logic          arvalid;
    logic          arready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready;
    logic [RW-1:0] results;
    logic          busy, done, error, timeout, overrun;

    frequency_result_reader #(
        .C_M00_AXI_ADDR_WIDTH(AW),
        .C_M00_AXI_DATA_WIDTH(DW),
        .BASE_ADDRESS(0),
        .REGISTERS_NUMBER(NREG),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .m00_axi_aclk(clk),
        .m00_axi_aresetn(rst_n),
        .irq(irq),
        .m00_axi_araddr(araddr),
        .m00_axi_arprot(arprot),
        .m00_axi_arvalid(arvalid),
        .m00_axi_arready(arready),
        .m00_axi_rdata(rdata),
        .m00_axi_rresp(rresp),
        .m00_axi_rvalid(rvalid),
        .m00_axi_rready(rready),
        .results(results),
        .busy(busy),
        .done(done),
        .error(error),
        .timeout(timeout),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [RW-1:0] got,
                         input logic [RW-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    logic [DW-1:0] mem [NREG];

    function automatic logic [RW-1:0] pack_mem();
        logic [RW-1:0] r;
        r = '0;
        for (int i = 0; i < NREG; i++) r[i*DW +: DW] = mem[i];
        return r;
    endfunction

    // slave
    int            ar_wait = 0;
    int            r_wait  = 0;
    int            bad_idx = -1;
    int            ar_cnt, r_cnt;
    bit            pend;
    logic [AW-1:0] r_addr;
    logic          arv_s, rr_s;
    logic [AW-1:0] ara_s;

    task automatic slave_reset();
        arready = (ar_wait == 0);
        rvalid  = 1'b0;
        rdata   = '0;
        rresp   = 2'b00;
        pend    = 1'b0;
        ar_cnt  = 0;
        r_cnt   = 0;
    endtask

    initial begin : slave
        bit ar_fire, r_fire;
        int idx;
        forever begin
            @(negedge clk);
            arv_s = arvalid;
            ara_s = araddr;
            rr_s  = rready;
            @(posedge clk);
            ar_fire = arv_s && arready;
            r_fire  = rvalid && rr_s;
            #1;
            if (r_fire) begin
                rvalid = 1'b0;
                pend   = 1'b0;
            end
            if (ar_fire) begin
                pend    = 1'b1;
                r_cnt   = 0;
                r_addr  = ara_s;
                ar_cnt  = 0;
                arready = (ar_wait == 0);
            end else if (arv_s && !arready) begin
                ar_cnt++;
                if (ar_cnt >= ar_wait) arready = 1'b1;
            end
            if (pend && !rvalid) begin
                if (r_cnt >= r_wait) begin
                    idx    = int'(r_addr[AW-1:2]);
                    rvalid = 1'b1;
                    rdata  = (idx < NREG) ? mem[idx] : 32'hDEAD_BEEF;
                    rresp  = (idx == bad_idx) ? 2'b10 : 2'b00;
                end else begin
                    r_cnt++;
                end
            end
        end
    end

    // monitor
    logic [AW-1:0] ar_log [$];
    int            done_cnt  = 0;
    int            proto_err = 0;
    bit            hold_chk  = 1'b1;
    bit            prev_wait = 1'b0;
    logic [AW-1:0] prev_addr = '0;

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (arvalid && arready) ar_log.push_back(araddr);
            if (done) done_cnt++;
            if (rready && arvalid) proto_err++;
            if (hold_chk && prev_wait && (!arvalid || araddr !== prev_addr))
                proto_err++;
            prev_wait = arvalid && !arready;
            prev_addr = araddr;
        end
    end

    task automatic clear_logs();
        ar_log.delete();
        done_cnt  = 0;
        proto_err = 0;
    endtask

    task automatic wait_done(output int at, output int busy_n,
                             output int arv_n);
        at = -1;
        busy_n = 0;
        arv_n = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (done) begin
                at = cyc;
                break;
            end
            if (busy) busy_n++;
            if (arvalid) arv_n++;
        end
        if (at < 0) check("done_seen", 0, 1);
    endtask

    task automatic check_log(input string tag, input int n);
        logic [AW-1:0] got;
        check({tag, "_ar_count"}, ar_log.size(), n);
        for (int i = 0; i < n; i++) begin
            got = (i < ar_log.size()) ? ar_log[i] : '1;
            check($sformatf("%s_addr%0d", tag, i), got, i * 4);
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int at, bn, an, t0;
        logic [RW-1:0] prev;

        rst_n = 1'b0;
        irq   = 1'b0;
        for (int i = 0; i < NREG; i++) mem[i] = 32'((i + 1) * 5000);
        slave_reset();

        repeat (2) @(negedge clk);
        check("rst_results", results, '0);
        check("rst_flags", {busy, done, error, timeout, overrun,
                            arvalid, rready}, '0);
        check("rst_araddr", araddr, '0);
        check("arprot", arprot, 3'b000);
        rst_n = 1'b1;

        // 1: zero-wait run, irq sampled at edge 10
        while (cyc < 9) @(negedge clk);
        clear_logs();
        irq = 1'b1;
        wait_done(at, bn, an);
        check("t1_done_edge", at, 23);
        check("t1_busy_cycles", bn, 13);
        check("t1_busy_end", busy, 0);
        check("t1_results", results, pack_mem());
        check("t1_flags", {error, timeout, overrun}, 3'b000);
        check_log("t1", NREG);
        repeat (3) @(negedge clk);
        check("t1_done_cnt", done_cnt, 1);
        check("t1_proto", proto_err, 0);

        // 2: wait states on both channels, fresh data
        irq = 1'b0;
        for (int i = 0; i < NREG; i++) mem[i] = 32'hA5A5_0000 + 32'(i * 'h111);
        ar_wait = 3;
        r_wait  = 2;
        slave_reset();
        repeat (2) @(negedge clk);
        clear_logs();
        irq = 1'b1;
        wait_done(at, bn, an);
        check("t2_results", results, pack_mem());
        check("t2_error", error, 0);
        check_log("t2", NREG);
        repeat (3) @(negedge clk);
        check("t2_done_cnt", done_cnt, 1);
        check("t2_proto", proto_err, 0);

        // 3: SLVERR on read 3 keeps previous results
        prev = pack_mem();
        irq = 1'b0;
        ar_wait = 0;
        r_wait  = 0;
        bad_idx = 3;
        slave_reset();
        repeat (2) @(negedge clk);
        clear_logs();
        t0 = cyc + 1;
        irq = 1'b1;
        wait_done(at, bn, an);
        check("t3_done_edge", at - t0, 9);
        check("t3_err_flags", {error, timeout}, 2'b10);
        check("t3_results", results, prev);
        repeat (4) @(negedge clk);
        check_log("t3", 4);
        check("t3_done_cnt", done_cnt, 1);
        check("t3_busy", busy, 0);

        // 4: arready stuck low -> timeout
        irq = 1'b0;
        bad_idx = -1;
        ar_wait = 1000;
        slave_reset();
        hold_chk = 1'b0;
        repeat (2) @(negedge clk);
        clear_logs();
        t0 = cyc + 1;
        irq = 1'b1;
        wait_done(at, bn, an);
        check("t4_done_edge", at - t0, 17);
        check("t4_arvalid_cycles", an, TMO);
        check("t4_err_flags", {error, timeout}, 2'b01);
        check("t4_results", results, prev);
        repeat (2) @(negedge clk);
        check("t4_arvalid_after", arvalid, 0);
        check("t4_ar_count", ar_log.size(), 0);
        check("t4_done_cnt", done_cnt, 1);
        hold_chk = 1'b1;

        // 5: second irq edge while busy
        irq = 1'b0;
        ar_wait = 0;
        slave_reset();
        repeat (2) @(negedge clk);
        clear_logs();
        t0 = cyc + 1;
        irq = 1'b1;
        repeat (2) @(negedge clk);
        irq = 1'b0;
        repeat (2) @(negedge clk);
        irq = 1'b1;
        @(negedge clk);
        check("t5_overrun_set", {overrun, busy, timeout}, 3'b110);
        wait_done(at, bn, an);
        check("t5_done1_edge", at - t0, 13);
        @(negedge clk);
        check("t5_restart", {busy, overrun}, 2'b10);
        wait_done(at, bn, an);
        check("t5_done2_edge", at - t0, 27);
        repeat (3) @(negedge clk);
        check("t5_done_cnt", done_cnt, 2);
        check("t5_ar_count", ar_log.size(), 2 * NREG);
        check("t5_results", results, pack_mem());

        // 6: reset during DATA of read 2, then a clean run
        irq = 1'b0;
        repeat (2) @(negedge clk);
        t0 = cyc + 1;
        irq = 1'b1;
        for (int n = 0; n < 50 && cyc < t0 + 5; n++) @(negedge clk);
        check("t6_in_data", {rready, arvalid, busy}, 3'b101);
        #2;
        rst_n = 1'b0;
        irq = 1'b0;
        slave_reset();
        #1;
        check("t6_rst_hs", {arvalid, rready, busy, done}, 4'b0000);
        check("t6_rst_results", results, '0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        clear_logs();
        t0 = cyc + 1;
        irq = 1'b1;
        wait_done(at, bn, an);
        check("t6_done_edge", at - t0, 13);
        check("t6_results", results, pack_mem());
        check("t6_flags", {error, timeout, overrun}, 3'b000);
        check_log("t6", NREG);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
